dmem_arbiter: RTL

- Shares the single data-memory port between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA loader).
- Arbitrates with port-0 priority plus a starvation guard for port 1.
- Translates access size into memory byte enables, checks alignment, sequences MemRead/MemWrite strobes, and returns registered read data.
- Sits between the core/loader and the data memory.

---
 rtl/dmem_arb_pkg.sv | 41 ++++
 rtl/dmem_arb_prio.sv | 54 +++++
 rtl/dmem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, access sizes,
// byte-enable patterns, and the size/alignment decode used at grant time.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Byte enables address the low lanes; the memory itself shifts by address.
  function automatic logic [3:0] size_to_be(input logic [1:0] size);
    case (size)
      SZ_B:    return BE_B;
      SZ_H:    return BE_H;
      SZ_W:    return BE_W;
      default: return 4'b0000;
    endcase
  endfunction

  // The reserved size encoding is treated as an error alongside misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Winner select for the two data-memory requesters: port 0 wins by default, port 1 wins
// once it has lost STARVE_MAX consecutive arbitrations. Grants are combinational with decide.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p0_req,
  input  logic p1_req,
  input  logic decide,
  output logic gnt0,
  output logic gnt1
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic       p1_first;

  assign p1_first = (starve_q == STARVE_LIM);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (decide) begin
      if (p1_req && (!p0_req || p1_first)) begin
        gnt1 = 1'b1;
      end else if (p0_req) begin
        gnt0 = 1'b1;
      end
    end
  end

  // Only an arbitration that port 1 actually lost counts toward starvation.
  always_comb begin
    starve_d = starve_q;
    if (gnt1) begin
      starve_d = 4'd0;
    end else if (decide && p1_req && !p1_first) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core LSU (port 0) and a debug/DMA loader (port 1);
// one access per three cycles. Define DMEM_ARB_GNT_CNT_EN to build per-port grant counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic              p0_us,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic              p1_us,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_us,
  output logic [3:0]        mem_byte_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       p0_gnt_cnt,
  output logic [15:0]       p1_gnt_cnt
);

  state_e state_q, state_d;

  logic gnt0, gnt1, take, decide;

  logic              sel_we, sel_us;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              cmd_we_q, cmd_us_q, cmd_err_q, owner_q;
  logic [1:0]        cmd_size_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // rst_n gates decide so no grant can escape while reset is held.
  assign decide = (state_q == IDLE) && rst_n;

  dmem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk    (clk),
    .rst_n  (rst_n),
    .p0_req (p0_req),
    .p1_req (p1_req),
    .decide (decide),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign take   = gnt0 || gnt1;
  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;

  assign sel_we    = gnt1 ? p1_we    : p0_we;
  assign sel_us    = gnt1 ? p1_us    : p0_us;
  assign sel_size  = gnt1 ? p1_size  : p0_size;
  assign sel_addr  = gnt1 ? p1_addr  : p0_addr;
  assign sel_wdata = gnt1 ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stores and rejected accesses complete with zero data.
  assign rdata_d = (cmd_we_q || cmd_err_q) ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_we_q    <= 1'b0;
      cmd_us_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      owner_q     <= 1'b0;
      cmd_size_q  <= 2'b00;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (take) begin
        cmd_we_q    <= sel_we;
        cmd_us_q    <= sel_us;
        cmd_err_q   <= misaligned(sel_size, sel_addr[1:0]);
        owner_q     <= gnt1;
        cmd_size_q  <= sel_size;
        cmd_addr_q  <= sel_addr;
        cmd_wdata_q <= sel_wdata;
      end
      if (state_q == ACCESS) begin
        rdata_q <= rdata_d;
      end
    end
  end

  // The memory bus is only driven during a legal ACCESS; everything else parks at zero.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_us      = 1'b0;
    mem_byte_en = 4'b0000;
    mem_addr    = '0;
    mem_wdata   = '0;
    p0_rvalid   = 1'b0;
    p0_err      = 1'b0;
    p0_rdata    = '0;
    p1_rvalid   = 1'b0;
    p1_err      = 1'b0;
    p1_rdata    = '0;
    case (state_q)
      ACCESS: begin
        if (!cmd_err_q) begin
          mem_read    = !cmd_we_q;
          mem_write   = cmd_we_q;
          mem_us      = cmd_us_q;
          mem_byte_en = size_to_be(cmd_size_q);
          mem_addr    = cmd_addr_q;
          mem_wdata   = cmd_we_q ? cmd_wdata_q : '0;
        end
      end
      RESP: begin
        if (owner_q) begin
          p1_rvalid = 1'b1;
          p1_err    = cmd_err_q;
          p1_rdata  = rdata_q;
        end else begin
          p0_rvalid = 1'b1;
          p0_err    = cmd_err_q;
          p0_rdata  = rdata_q;
        end
      end
      default: ;
    endcase
  end

`ifdef DMEM_ARB_GNT_CNT_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      if (gnt0 && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (gnt1 && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign p0_gnt_cnt = cnt0_q;
  assign p1_gnt_cnt = cnt1_q;
`else
  assign p0_gnt_cnt = 16'd0;
  assign p1_gnt_cnt = 16'd0;
`endif

endmodule
